// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and default
// timing/address constants.
package loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } loader_state_t;

    localparam int LOADER_ADDR_STEP  = 4;
    localparam int LOADER_WRITE_HOLD = 2;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs a byte stream into big-endian words; the first byte lands in the top lane.
// word/word_valid are combinational so the FSM can act on the final byte's edge.
module word_assembler
    import loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              flush,
    input  logic              byte_en,
    input  logic [7:0]        byte_data,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);

    localparam int NB    = bytes_per_word(DATA_W);
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shreg;

    assign word       = DATA_W'({shreg, byte_data});
    assign word_valid = byte_en && (idx == IDX_W'(NB - 1));

    always_ff @(posedge clk) begin
        if (clr || flush) begin
            idx   <= '0;
            shreg <= '0;
        end else if (byte_en) begin
            shreg <= word;
            idx   <= word_valid ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Program-load initiator: assembles host bytes into words and holds each write
// for WRITE_HOLD cycles so the half-rate core clock samples it.
//   state   | meaning
//   IDLE    | waiting for start
//   COLLECT | accepting bytes of the current word
//   WRITE   | prog_write held for WRITE_HOLD cycles
//   DONE    | one-cycle completion pulse
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int ADDR_STEP  = LOADER_ADDR_STEP,
    parameter int WRITE_HOLD = LOADER_WRITE_HOLD
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              prog_write,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] prog_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam int HOLD_W = $clog2(WRITE_HOLD + 1);

    loader_state_t     state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        remaining;
    logic              byte_en;
    logic              start_acc;
    logic [DATA_W-1:0] word;
    logic              word_valid;

    // byte_ready is only ever high in COLLECT, so it alone qualifies acceptance
    assign byte_en   = byte_ready && byte_valid;
    assign start_acc = (state == S_IDLE) && start;

    word_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk        (clk),
        .clr        (clr),
        .flush      (start_acc),
        .byte_en    (byte_en),
        .byte_data  (byte_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (start) state_nxt = (word_count != 8'd0) ? S_COLLECT : S_DONE;
            S_COLLECT: if (word_valid) state_nxt = S_WRITE;
            S_WRITE:   if (hold_cnt == '0) state_nxt = (remaining == 8'd1) ? S_DONE : S_COLLECT;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= S_IDLE;
            hold_cnt   <= '0;
            addr       <= '0;
            remaining  <= '0;
            byte_ready <= 1'b0;
            prog_write <= 1'b0;
            prog_addr  <= '0;
            prog_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            checksum   <= '0;
        end else begin
            state      <= state_nxt;
            byte_ready <= (state_nxt == S_COLLECT);
            prog_write <= (state_nxt == S_WRITE);
            busy       <= (state_nxt == S_COLLECT) || (state_nxt == S_WRITE);
            done       <= (state_nxt == S_DONE);
            unique case (state)
                S_IDLE: if (start) begin
                    addr      <= base_addr;
                    remaining <= word_count;
                    checksum  <= '0;
                end
                S_COLLECT: if (word_valid) begin
                    prog_addr <= addr;
                    prog_data <= word;
                    checksum  <= checksum ^ word;
                    hold_cnt  <= HOLD_W'(WRITE_HOLD - 1);
                end
                S_WRITE: begin
                    if (hold_cnt == '0) begin
                        addr      <= addr + ADDR_W'(ADDR_STEP);
                        remaining <= remaining - 8'd1;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected writes and
// checksums, a negedge monitor pops and compares as the DUT presents them.
module tb_program_loader;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        last;
    } wr_t;

    logic        clk = 1'b0;
    logic        clr, start, byte_valid;
    logic [7:0]  base_addr, word_count, byte_data;
    logic        byte_ready, prog_write, busy, done;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data, checksum;

    logic        h1_start, h1_valid;
    logic [7:0]  h1_data;
    logic        h1_ready, h1_write, h1_busy, h1_done;
    logic [7:0]  h1_addr;
    logic [31:0] h1_pdata, h1_cs;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_seen = 0;

    wr_t         wq[$];
    logic [31:0] cq[$];
    logic [31:0] wbuf[0:15];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    program_loader dut (
        .clk(clk), .clr(clr), .start(start), .base_addr(base_addr),
        .word_count(word_count), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .prog_write(prog_write), .prog_addr(prog_addr),
        .prog_data(prog_data), .busy(busy), .done(done), .checksum(checksum)
    );

    program_loader #(.WRITE_HOLD(1)) dut_h1 (
        .clk(clk), .clr(clr), .start(h1_start), .base_addr(8'h40),
        .word_count(8'd3), .byte_valid(h1_valid), .byte_data(h1_data),
        .byte_ready(h1_ready), .prog_write(h1_write), .prog_addr(h1_addr),
        .prog_data(h1_pdata), .busy(h1_busy), .done(h1_done), .checksum(h1_cs)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // main-DUT monitor
    logic prev_pw = 1'b0;
    int   width = 0;
    wr_t  cur = '0;
    always @(negedge clk) begin
        if (prog_write && !prev_pw) begin
            width = 0;
            if (wq.size() == 0) timeout("unexpected_write");
            else cur = wq.pop_front();
        end
        if (prog_write) begin
            width++;
            check("write_addr", {24'd0, prog_addr}, {24'd0, cur.addr});
            check("write_data", prog_data, cur.data);
            check("ready_in_write", {31'd0, byte_ready}, 32'd0);
        end
        if (!prog_write && prev_pw) begin
            check("write_width", 32'(width), 32'd2);
            check("done_after_last", {31'd0, done}, {31'd0, cur.last});
        end
        if (done) begin
            check("busy_at_done", {31'd0, busy}, 32'd0);
            if (cq.size() == 0) timeout("unexpected_done");
            else check("checksum", checksum, cq.pop_front());
            done_seen++;
        end
        prev_pw = prog_write;
    end

    // WRITE_HOLD=1 monitor
    logic h1_prev = 1'b0;
    int   h1_rises = 0, h1_last = 0, h1_w = 0, h1_dones = 0;
    logic [31:0] h1_exp[0:2];
    always @(negedge clk) begin
        if (h1_write && !h1_prev) begin
            if (h1_rises > 0) check("h1_period", 32'(cyc - h1_last), 32'd5);
            if (h1_rises < 3) begin
                check("h1_data", h1_pdata, h1_exp[h1_rises]);
                check("h1_addr", {24'd0, h1_addr}, 32'(8'h40 + 4 * h1_rises));
            end
            h1_last = cyc;
            h1_rises++;
            h1_w = 0;
        end
        if (h1_write) h1_w++;
        if (!h1_write && h1_prev) check("h1_width", 32'(h1_w), 32'd1);
        if (h1_done) begin
            check("h1_checksum", h1_cs, h1_exp[0] ^ h1_exp[1] ^ h1_exp[2]);
            h1_dones++;
        end
        h1_prev = h1_write;
    end

    task automatic send_byte(input logic [7:0] b);
        int g = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (!byte_ready) timeout("byte_accept");
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] base, input int cnt, input int gap, input bit glitch);
        logic [31:0] cs;
        logic [31:0] w;
        int d0, g, n;
        cs = '0;
        for (int i = 0; i < cnt; i++) begin
            wq.push_back('{addr: 8'(base + 8'(4 * i)), data: wbuf[i], last: (i == cnt - 1)});
            cs ^= wbuf[i];
        end
        cq.push_back(cs);
        d0 = done_seen;
        base_addr  = base;
        word_count = 8'(cnt);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (cnt == 0) begin
            check("zero_done_next", {31'd0, done}, 32'd1);
            check("zero_busy", {31'd0, busy}, 32'd0);
        end
        for (int k = 0; k < cnt * 4; k++) begin
            if (glitch && k == 4) begin
                start = 1'b1; base_addr = 8'h80; word_count = 8'd5;
            end
            if (glitch && k == 8) start = 1'b0;
            n = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 3)) : 0;
            if (k > 0) repeat (n) begin
                byte_valid = 1'b0;
                @(posedge clk); #1;
            end
            w = wbuf[k / 4];
            send_byte(w[31 - 8 * (k % 4) -: 8]);
        end
        g = 0;
        while (done_seen == d0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (done_seen == d0) timeout("load_done");
        check("writes_drained", 32'(wq.size()), 32'd0);
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; byte_valid = 1'b0;
        base_addr = '0; word_count = '0; byte_data = '0;
        h1_start = 1'b0; h1_valid = 1'b0; h1_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_prog_write", {31'd0, prog_write}, 32'd0);
        check("rst_prog_addr", {24'd0, prog_addr}, 32'd0);
        check("rst_prog_data", prog_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_checksum", checksum, 32'd0);
        clr = 1'b0;
        @(posedge clk); #1;

        wbuf[0] = 32'h20080005;
        run_load(8'h00, 1, 0, 1'b0);

        wbuf[0] = 32'h11223344; wbuf[1] = 32'hA5A55A5A; wbuf[2] = 32'hDEADBEEF;
        run_load(8'h10, 3, 1, 1'b1);

        wbuf[0] = 32'h0BADF00D; wbuf[1] = 32'hCAFEF00D;
        run_load(8'hFC, 2, 0, 1'b0);

        run_load(8'h55, 0, 0, 1'b0);

        // abort mid-word: only word 0 should ever be written
        wbuf[0] = 32'h01234567; wbuf[1] = 32'h89ABCDEF;
        wq.push_back('{addr: 8'h20, data: wbuf[0], last: 1'b0});
        base_addr = 8'h20; word_count = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) send_byte(wbuf[0][31 - 8 * k -: 8]);
        send_byte(8'h89);
        send_byte(8'hAB);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("clr_prog_write", {31'd0, prog_write}, 32'd0);
        check("clr_prog_addr", {24'd0, prog_addr}, 32'd0);
        check("clr_prog_data", prog_data, 32'd0);
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_checksum", checksum, 32'd0);
        check("clr_writes_drained", 32'(wq.size()), 32'd0);
        @(posedge clk); #1;

        wbuf[0] = 32'hFEEDFACE; wbuf[1] = 32'h13579BDF;
        run_load(8'h30, 2, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int cnt;
            cnt = int'($urandom_range(1, 6));
            for (int i = 0; i < cnt; i++) wbuf[i] = $urandom;
            run_load(8'($urandom), cnt, int'($urandom_range(0, 2)), 1'b0);
        end

        // WRITE_HOLD=1 build, full-rate bytes 0x01..0x0C
        h1_exp[0] = 32'h01020304; h1_exp[1] = 32'h05060708; h1_exp[2] = 32'h090A0B0C;
        h1_start = 1'b1;
        @(posedge clk); #1;
        h1_start = 1'b0;
        for (int b = 1; b <= 12; b++) begin
            int g = 0;
            h1_valid = 1'b1;
            h1_data  = 8'(b);
            while (!h1_ready && g < 50) begin
                @(posedge clk); #1;
                g++;
            end
            if (!h1_ready) timeout("h1_byte_accept");
            @(posedge clk); #1;
        end
        h1_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("h1_writes", 32'(h1_rises), 32'd3);
        check("h1_dones", 32'(h1_dones), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Initiator side of the processor's program-load port. It takes a byte stream through a valid/ready handshake and assembles big-endian 32-bit instruction words. Each word is driven onto `prog_write`/`prog_addr`/`prog_data` for a fixed hold window, so the processor's half-rate core clock is guaranteed to sample it. It sits beside the processor top level, fed by a host link (UART/JTAG bridge), and holds the CPU in clear while loading.

## Interface
- `ADDR_W`, 8: width of `prog_addr`.
- `DATA_W`, 32: instruction word width; must be a multiple of 8.
- `ADDR_STEP`, 4: address increment per word, matching PC stepping.
- `WRITE_HOLD`, 2: cycles each write is held; must be ≥1. Default 2 covers the divide-by-2 core clock.
- `clk`  in  1  single clock; all logic on its rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `start`  in  1  load request; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first write address; latched on accepted start.
- `word_count`  in  8  number of words to load; latched on accepted start.
- `byte_valid`  in  1  host byte available.
- `byte_data`  in  8  host byte.
- `byte_ready`  out  1  loader accepts byte this cycle.
- `prog_write`  out  1  program-memory write enable.
- `prog_addr`  out  ADDR_W  program-memory address.
- `prog_data`  out  DATA_W  instruction word.
- `busy`  out  1  load in progress; also used as CPU hold (ORed into processor `clr`).
- `done`  out  1  one-cycle pulse at load completion.
- `checksum`  out  DATA_W  XOR of all words written in current/last load.

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: `start`=1 latches `base_addr` and `word_count`, and clears `checksum` and the byte index.
  - With `word_count`≠0, go to COLLECT; with `word_count`=0, go to DONE.
- COLLECT: `byte_ready`=1. A byte is accepted when `byte_valid`&&`byte_ready` at the clock edge.
  - The first byte of a word goes to [31:24], then [23:16], [15:8], [7:0].
  - Acceptance of the 4th byte → WRITE.
- WRITE: `prog_write`=1 for exactly WRITE_HOLD cycles, with `prog_addr`/`prog_data` stable across the window. `byte_ready`=0.
  - `checksum` ^= word, updated on entry to WRITE.
  - At window end the address advances by ADDR_STEP and the remaining count decrements.
  - If the remaining count reaches 0, go to DONE; otherwise go to COLLECT.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy` = (state is COLLECT or WRITE).
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent. With defaults, a `word_count` over 64 overwrites earlier words; this is legal.
- `start` outside IDLE is ignored. Bytes presented outside COLLECT are not accepted and not consumed.
- `clr` at any state: on the next edge return to IDLE and drop all outputs to reset values. A partial word is discarded.
- Reset values: `byte_ready`=0, `prog_write`=0, `prog_addr`=0, `prog_data`=0, `busy`=0, `done`=0, `checksum`=0.
- All outputs are registered; none has a combinational path from inputs.

## Timing
- Start accepted at edge N → COLLECT from N+1; `byte_ready`=1 in that cycle.
- Back-to-back bytes: one per cycle at full rate.
- 4th byte accepted at edge M → `prog_write`=1 in cycles M+1..M+WRITE_HOLD.
- Next COLLECT at M+WRITE_HOLD+1.
- Minimum per word is 4+WRITE_HOLD cycles (6 with defaults).
- `done` is asserted the cycle after the last write window ends; `busy` is already 0 in that cycle.
- `word_count`=0: `done` at N+1, no writes.
- `byte_valid` may drop between bytes; the loader waits indefinitely with no timeout.

## Structure
- Shared package `loader_pkg`: state enum `loader_state_t` (IDLE, COLLECT, WRITE, DONE) and the default constants for ADDR_STEP and WRITE_HOLD.
- One natural sub-module, `word_assembler`: byte index counter plus shift register, with outputs `word` and `word_valid`. The FSM, hold counter, address/count registers and checksum stay in `program_loader`.

## Test plan
- Single word: start, base 0x00, count 1, bytes 0x20,0x08,0x00,0x05 → one write of 0x20080005 @0x00, `prog_write` high exactly 2 cycles, `done` pulse, `checksum`=0x20080005.
- Three words from base 0x10, `byte_valid` toggling every other cycle → writes at 0x10, 0x14, 0x18 in byte order; `byte_ready`=0 during every write window.
- Wrap: base 0xFC, count 2 → writes at 0xFC then 0x00.
- Count 0 → `done` the cycle after start, no `prog_write`, `busy` never high.
- `clr` asserted after 2 bytes of word 2 → next cycle IDLE, all outputs 0. A fresh start then loads cleanly with no stale bytes.
- `start` pulsed mid-load, and `WRITE_HOLD`=1 build → start ignored; each write is 1 cycle wide and the per-word period is 5 cycles.
